// File: rtl/match_event_logger_if.sv
`default_nettype none
// ============================================================================
//  Module   : match_event_logger_if
//  Purpose  : Bundles the detector-side and host-side signals of the match
//             event logger into one interface.
//             master : the upstream/host side. It drives q, clr and rd_en
//                      and observes the FIFO and status outputs.
//             slave  : the logger itself.
//  Signals  : q, clr, rd_en            -> logger
//             rd_data, empty, full,    <- logger
//             level, match_cnt, overflow
//             irq                      <- logger (only with MATCH_IRQ_EN)
//  Macro    : MATCH_IRQ_EN adds the irq signal.
//  Revision : 1.0  initial release
// ============================================================================
interface match_event_logger_if #(
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
);
    localparam int c_LVL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                   q;
    logic                   clr;
    logic                   rd_en;
    logic [TS_WIDTH-1:0]    rd_data;
    logic                   empty;
    logic                   full;
    logic [c_LVL_WIDTH-1:0] level;
    logic [CNT_WIDTH-1:0]   match_cnt;
    logic                   overflow;
`ifdef MATCH_IRQ_EN
    logic                   irq;
`endif

    modport master (
        output q,
        output clr,
        output rd_en,
        input  rd_data,
        input  empty,
        input  full,
        input  level,
        input  match_cnt,
        input  overflow
`ifdef MATCH_IRQ_EN
        ,
        input  irq
`endif
    );

    modport slave (
        input  q,
        input  clr,
        input  rd_en,
        output rd_data,
        output empty,
        output full,
        output level,
        output match_cnt,
        output overflow
`ifdef MATCH_IRQ_EN
        ,
        output irq
`endif
    );
endinterface : match_event_logger_if
`default_nettype wire

// File: rtl/match_event_logger.sv
`default_nettype none
// ============================================================================
//  Module   : match_event_logger
//  Purpose  : Consumer stage downstream of the serial 1010 detector. Every
//             cycle with q=1 is one match. Each match is stamped with a
//             free-running bit-time counter and pushed into a small show-ahead
//             FIFO. A saturating total-match counter and a sticky overflow
//             flag are kept for host read-out.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset, dominant over all inputs
//             bus  - match_event_logger_if.slave (q, clr, rd_en in;
//                    rd_data, empty, full, level, match_cnt, overflow,
//                    [irq] out)
//  Params   : TS_WIDTH, FIFO_DEPTH (power of 2, >= 2), CNT_WIDTH,
//             IRQ_THRESH (1..FIFO_DEPTH, only meaningful with MATCH_IRQ_EN).
//             The interface instance must use the same TS_WIDTH, FIFO_DEPTH
//             and CNT_WIDTH.
//  Macro    : MATCH_IRQ_EN - adds the registered irq output.
//  Revision : 1.0  initial release
// ============================================================================
module match_event_logger #(
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int IRQ_THRESH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    match_event_logger_if.slave  bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    // Elaboration-time parameter sanity checks.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("match_event_logger: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (IRQ_THRESH < 1 || IRQ_THRESH > FIFO_DEPTH) begin : g_chk_thresh
        $error("match_event_logger: IRQ_THRESH must be within 1..FIFO_DEPTH");
    end

    logic [TS_WIDTH-1:0]  r_ts;
    logic [TS_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic [c_LVL_W-1:0]   w_level_nxt;
    logic                 w_ovf_nxt;

    always_comb begin
        w_full  = (r_level == c_LVL_W'(FIFO_DEPTH));
        w_empty = (r_level == '0);
        // A pop in the same cycle frees the slot, so a push into a full
        // FIFO is accepted when rd_en is high.
        w_push  = bus.q && (!w_full || bus.rd_en);
        // Pop needs a stored entry; an empty FIFO is never bypassed.
        w_pop   = bus.rd_en && !w_empty;
        w_drop  = bus.q && w_full && !bus.rd_en;

        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_LVL_W'(1);
        end

        // clr takes priority over a drop in the same cycle, matching how
        // clr also wins over a coincident increment of the match counter.
        w_ovf_nxt = r_ovf;
        if (bus.clr) begin
            w_ovf_nxt = 1'b0;
        end else if (w_drop) begin
            w_ovf_nxt = 1'b1;
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ts    <= r_ts + TS_WIDTH'(1);
            r_level <= w_level_nxt;
            r_ovf   <= w_ovf_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (bus.clr) begin
                r_cnt <= '0;
            end else if (bus.q && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    assign bus.rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.level     = r_level;
    assign bus.match_cnt = r_cnt;
    assign bus.overflow  = r_ovf;

`ifdef MATCH_IRQ_EN
    logic r_irq;

    // Registered from the next-state values so irq moves in the same cycle
    // as level and overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_level_nxt >= c_LVL_W'(IRQ_THRESH)) | w_ovf_nxt;
        end
    end

    assign bus.irq = r_irq;
`endif

endmodule : match_event_logger
`default_nettype wire
